// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// One winner per grant; address, data and NZP are registered and issued the next cycle.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_setcc,
    input  logic                        flush,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic                        cc_load,
    output logic [2:0]                  cc_nzp,
    output logic                        busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // {N,Z,P} classification of a two's-complement write value.
    function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] d);
        logic [2:0] r;
        if (d[DATA_W-1]) begin
            r = 3'b100;
        end else if (d == {DATA_W{1'b0}}) begin
            r = 3'b010;
        end else begin
            r = 3'b001;
        end
        return r;
    endfunction

    // First set request at or after the pointer, searching upward with wrap-around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   p);
        logic [PTR_W-1:0] w;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        logic             found;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, p} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end else begin
                sum = sum;
            end
            idx = sum[PTR_W-1:0];
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    // Pointer advance with wrap from NUM_REQ-1 back to 0.
    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] w);
        logic [PTR_W-1:0] r;
        if (w == PTR_W'(NUM_REQ - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = w + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 cc_load_q, cc_load_d;
    logic [2:0]           cc_nzp_q, cc_nzp_d;
    logic                 busy_q, busy_d;

    logic [PTR_W-1:0]     win_s;
    logic [DATA_W-1:0]    win_data_s;

    assign win_s      = rr_pick(req, ptr_q);
    assign win_data_s = req_data[int'(win_s)*DATA_W +: DATA_W];

    // Next-state and next-output logic; write strobes are pulses, payload holds in IDLE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = {NUM_REQ{1'b0}};
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cc_load_d = 1'b0;
        cc_nzp_d  = cc_nzp_q;
        busy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && (|req)) begin
                    state_d        = WRITE;
                    ptr_d          = ptr_after(win_s);
                    gnt_d[win_s]   = 1'b1;
                    wr_en_d        = 1'b1;
                    wr_addr_d      = req_addr[int'(win_s)*ADDR_W +: ADDR_W];
                    wr_data_d      = win_data_s;
                    cc_load_d      = req_setcc[win_s];
                    cc_nzp_d       = nzp_of(win_data_s);
                    busy_d         = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs; reset abandons any in-flight write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= {PTR_W{1'b0}};
            gnt_q     <= {NUM_REQ{1'b0}};
            wr_en_q   <= 1'b0;
            wr_addr_q <= {ADDR_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
            cc_load_q <= 1'b0;
            cc_nzp_q  <= 3'b000;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cc_load_q <= cc_load_d;
            cc_nzp_q  <= cc_nzp_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign cc_load = cc_load_q;
    assign cc_nzp  = cc_nzp_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      t_req = '0;
    logic [AW-1:0]     t_addr [N];
    logic [DW-1:0]     t_data [N];
    logic [N-1:0]      t_setcc = '0;
    logic              flush = 1'b0;

    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      gnt;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              cc_load;
    logic [2:0]        cc_nzp;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit          m_busy;
    int          m_ptr;
    logic [N-1:0] m_gnt;
    logic        m_wr_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic        m_cc_load;
    logic [2:0]  m_nzp;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = t_addr[i];
            req_data[i*DW +: DW] = t_data[i];
        end
    end

    regfile_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req       (t_req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_setcc (t_setcc),
        .flush     (flush),
        .gnt       (gnt),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cc_load   (cc_load),
        .cc_nzp    (cc_nzp),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_nzp(input logic [DW-1:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 0) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_gnt = '0; m_wr_en = 0;
        m_addr = '0; m_data = '0; m_cc_load = 0; m_nzp = '0;
    endtask

    // One clock edge of the arbitration rules, applied to the inputs as sampled.
    task automatic model_step();
        int w;
        if (!rst_n) begin
            model_reset();
        end else if (m_busy) begin
            m_busy = 0; m_gnt = '0; m_wr_en = 0; m_cc_load = 0;
        end else if (!flush && t_req != 0) begin
            w = 0;
            for (int k = 0; k < N; k++) begin
                if (t_req[(m_ptr + k) % N]) begin
                    w = (m_ptr + k) % N;
                    break;
                end
            end
            m_busy    = 1;
            m_gnt     = N'(1 << w);
            m_wr_en   = 1;
            m_addr    = t_addr[w];
            m_data    = t_data[w];
            m_cc_load = t_setcc[w];
            m_nzp     = ref_nzp(t_data[w]);
            m_ptr     = (w + 1) % N;
        end
    endtask

    task automatic compare_all();
        check_eq("gnt",     gnt,     m_gnt);
        check_eq("wr_en",   wr_en,   m_wr_en);
        check_eq("wr_addr", wr_addr, m_addr);
        check_eq("wr_data", wr_data, m_data);
        check_eq("cc_load", cc_load, m_cc_load);
        check_eq("cc_nzp",  cc_nzp,  m_nzp);
        check_eq("busy",    busy,    m_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic sc);
        t_req[i]   = 1'b1;
        t_addr[i]  = a;
        t_data[i]  = d;
        t_setcc[i] = sc;
    endtask

    task automatic rand_payload(input int i);
        t_addr[i]  = AW'($urandom_range(0, 7));
        t_data[i]  = ($urandom_range(0, 3) == 0) ? 16'h0000 : DW'($urandom);
        t_setcc[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end
        model_reset();
        tick();
        tick();
        check_eq("rst_gnt", gnt, 3'b000);
        check_eq("rst_busy", busy, 1'b0);
        rst_n = 1'b1;

        // Reset during WRITE abandons the write
        set_req(0, 3'd3, 16'h1234, 1'b0);
        tick();
        check_eq("t1_wr_en", wr_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t1_async_wr_en", wr_en, 1'b0);
        check_eq("t1_async_gnt", gnt, 3'b000);
        check_eq("t1_async_ccl", cc_load, 1'b0);
        check_eq("t1_async_busy", busy, 1'b0);
        model_reset();
        t_req = '0;
        tick();
        rst_n = 1'b1;
        set_req(0, 3'd1, 16'h0001, 1'b0);
        set_req(1, 3'd2, 16'h0002, 1'b0);
        set_req(2, 3'd4, 16'h0004, 1'b0);
        tick();
        check_eq("t1_ptr0_gnt", gnt, 3'b001);
        t_req = '0;
        tick();

        // Single request with negative data
        set_req(1, 3'd5, 16'h8001, 1'b1);
        tick();
        check_eq("t2_gnt", gnt, 3'b010);
        check_eq("t2_addr", wr_addr, 3'd5);
        check_eq("t2_data", wr_data, 16'h8001);
        check_eq("t2_ccl", cc_load, 1'b1);
        check_eq("t2_nzp", cc_nzp, 3'b100);
        t_req = '0;
        tick();

        // All requesters held high from pointer 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, AW'(i), DW'(i + 7), 1'b0);
        for (int c = 0; c < 8; c++) begin
            logic [N-1:0] exp_g;
            tick();
            case (c)
                0: exp_g = 3'b001;
                2: exp_g = 3'b010;
                4: exp_g = 3'b100;
                6: exp_g = 3'b001;
                default: exp_g = 3'b000;
            endcase
            check_eq("t3_rot", gnt, exp_g);
        end
        t_req = '0;
        tick();

        // Zero data, with and without setcc
        set_req(2, 3'd6, 16'h0000, 1'b0);
        tick();
        check_eq("t4_wr_en", wr_en, 1'b1);
        check_eq("t4_ccl0", cc_load, 1'b0);
        t_req = '0;
        tick();
        set_req(2, 3'd6, 16'h0000, 1'b1);
        tick();
        check_eq("t4_ccl1", cc_load, 1'b1);
        check_eq("t4_nzp", cc_nzp, 3'b010);
        t_req = '0;
        tick();

        // Flush suppresses grants; pointer is 0 after requester 2
        flush = 1'b1;
        set_req(0, 3'd7, 16'h0042, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("t5_flush_gnt", gnt, 3'b000);
            check_eq("t5_flush_wr", wr_en, 1'b0);
        end
        flush = 1'b0;
        tick();
        check_eq("t5_gnt", gnt, 3'b001);
        check_eq("t5_nzp", cc_nzp, 3'b001);
        t_req = '0;
        tick();

        // Wrap-around: grant 1 then pointer=2, so 0 wins over 1
        set_req(1, 3'd2, 16'h0010, 1'b0);
        tick();
        check_eq("t6_g1", gnt, 3'b010);
        t_req = '0;
        tick();
        set_req(0, 3'd3, 16'h0020, 1'b0);
        set_req(1, 3'd4, 16'h0030, 1'b0);
        tick();
        check_eq("t6_wrap", gnt, 3'b001);
        t_req[0] = 1'b0;
        tick();
        tick();
        check_eq("t6_next", gnt, 3'b010);
        t_req = '0;
        tick();

        // Randomized traffic with flush, honouring the hold-until-granted handshake
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_gnt[i]) begin
                    if ($urandom_range(0, 1) == 0) t_req[i] = 1'b0;
                    else rand_payload(i);
                end else if (!t_req[i] && $urandom_range(0, 9) < 4) begin
                    t_req[i] = 1'b1;
                    rand_payload(i);
                end
            end
            flush = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
